// File: rtl/rv_data_mem.sv
// rv_data_mem: single-port data memory with fixed-latency, one-outstanding LSU response
module rv_data_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);
  localparam int AW = $clog2(DEPTH_WORDS) + 2;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY > 1 ? LATENCY - 2 : 0);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rword;
  logic err_q;
  logic accept, in_range;
  logic [AW-3:0] idx;
  logic unused_lsb;
  assign unused_lsb = ^data_addr_i[1:0];
  assign accept = (state == IDLE) && data_req_i;
  assign in_range = data_addr_i[31:AW] == '0;
  assign idx = data_addr_i[AW-1:2];
  // Stores commit at the acceptance edge; the array is never reset
  always_ff @(posedge clk_i) begin
    if (accept && data_we_i && in_range && !arst_i)
      for (int b = 0; b < 4; b++)
        if (data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
  end
  // State, latency counter and the response captured at acceptance
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= IDLE;
      cnt   <= '0;
      rword <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        err_q <= !in_range;
        rword <= (in_range && !data_we_i) ? mem[idx] : '0;
      end
    end
  end
  // Next-state: IDLE accepts, BUSY counts down, RESP always returns to IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (data_req_i) begin
        state_nxt = (LATENCY == 1) ? RESP : BUSY;
        cnt_nxt   = CNT_INIT;
      end
      BUSY: begin
        state_nxt = (cnt == '0) ? RESP : BUSY;
        cnt_nxt   = (cnt == '0) ? cnt : cnt - 3'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  assign data_rvalid_o = state == RESP;
  assign data_rdata_o  = data_rvalid_o ? rword : '0;
  assign data_err_o    = data_rvalid_o & err_q;
endmodule

// File: tb/tb_rv_data_mem.sv
// tb_rv_data_mem: scoreboard bench over three latency variants (1, 3, 4)
module tb_rv_data_mem;
  typedef struct {int d; int cyc; logic [31:0] rd; logic err;} exp_t;
  logic clk_i = 1'b0;
  logic arst_i = 1'b1;
  logic        req   [3];
  logic        we    [3];
  logic [3:0]  be    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        rvalid[3];
  logic [31:0] rdata [3];
  logic        err   [3];
  int lat [3] = '{1, 3, 4};
  logic [31:0] model [3][1024];
  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int acc;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  rv_data_mem #(.DEPTH_WORDS(1024), .LATENCY(1)) u0 (
    .clk_i(clk_i), .arst_i(arst_i), .data_req_i(req[0]), .data_we_i(we[0]), .data_be_i(be[0]),
    .data_addr_i(addr[0]), .data_wdata_i(wdata[0]), .data_rvalid_o(rvalid[0]),
    .data_rdata_o(rdata[0]), .data_err_o(err[0]));
  rv_data_mem #(.DEPTH_WORDS(1024), .LATENCY(3)) u1 (
    .clk_i(clk_i), .arst_i(arst_i), .data_req_i(req[1]), .data_we_i(we[1]), .data_be_i(be[1]),
    .data_addr_i(addr[1]), .data_wdata_i(wdata[1]), .data_rvalid_o(rvalid[1]),
    .data_rdata_o(rdata[1]), .data_err_o(err[1]));
  rv_data_mem #(.DEPTH_WORDS(1024), .LATENCY(4)) u2 (
    .clk_i(clk_i), .arst_i(arst_i), .data_req_i(req[2]), .data_we_i(we[2]), .data_be_i(be[2]),
    .data_addr_i(addr[2]), .data_wdata_i(wdata[2]), .data_rvalid_o(rvalid[2]),
    .data_rdata_o(rdata[2]), .data_err_o(err[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // Model update and expected response for a transaction accepted at edge count a_cyc
  function automatic void push(input int d, input bit w, input logic [3:0] b,
                               input logic [31:0] a, input logic [31:0] wd, input int a_cyc);
    exp_t x;
    bit ir = a < 32'h1000;
    x.d   = d;
    x.cyc = a_cyc + lat[d] - 1;
    x.err = !ir;
    x.rd  = (ir && !w) ? model[d][a[11:2]] : 32'h0;
    if (ir && w)
      for (int k = 0; k < 4; k++)
        if (b[k]) model[d][a[11:2]][8*k +: 8] = wd[8*k +: 8];
    q.push_back(x);
  endfunction
  // Response monitor: every rvalid must match the head of the scoreboard
  always @(negedge clk_i) begin
    for (int k = 0; k < 3; k++)
      if (rvalid[k]) begin
        if (q.size() == 0) chk($sformatf("unexpected_rvalid_dut%0d", k), 1, 0);
        else begin
          e = q.pop_front();
          chk("dut", k, e.d);
          chk("cycle", cyc, e.cyc);
          chk("rdata", rdata[k], e.rd);
          chk("err", {31'b0, err[k]}, {31'b0, e.err});
        end
      end
  end
  task automatic wait_done();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk_i);
    @(negedge clk_i);
    if (q.size() != 0) begin
      chk("timeout_pending", q.size(), 0);
      q.delete();
    end
  endtask
  task automatic drive(input int d, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] wd);
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
  endtask
  task automatic scramble(input int d);
    req[d] = 1'b0; we[d] = 1'($urandom); be[d] = 4'($urandom);
    addr[d] = $urandom; wdata[d] = $urandom;
  endtask
  task automatic issue(input int d, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] wd, input bit sync = 1);
    if (sync) @(negedge clk_i);
    drive(d, w, b, a, wd);
    @(posedge clk_i);
    #1;
    push(d, w, b, a, wd, cyc);
    scramble(d);
    wait_done();
  endtask
  initial begin
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; be[d] = '0; addr[d] = '0; wdata[d] = '0;
    end
    repeat (2) @(negedge clk_i);
    for (int d = 0; d < 3; d++) begin
      chk("reset_rvalid", {31'b0, rvalid[d]}, 0);
      chk("reset_rdata", rdata[d], 0);
      chk("reset_err", {31'b0, err[d]}, 0);
    end
    arst_i = 1'b0;
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 16; w++) issue(d, 1, 4'hF, 32'(w * 4), $urandom);
    issue(0, 1, 4'hF, 32'h10, 32'hDEADBEEF);
    issue(0, 0, 4'hF, 32'h10, 32'h0);
    issue(0, 1, 4'hF, 32'h20, 32'h11223344);
    issue(0, 1, 4'b0010, 32'h20, 32'h0000AA00);
    issue(0, 0, 4'hF, 32'h20, 32'h0);
    chk("merge_model", model[0][8], 32'h1122AA44);
    issue(0, 1, 4'b0000, 32'h20, 32'hFFFFFFFF);
    issue(0, 0, 4'hF, 32'h22, 32'h0);
    issue(0, 1, 4'hF, 32'h0, 32'h00000055);
    issue(0, 0, 4'hF, 32'h1000, 32'h0);
    issue(0, 1, 4'hF, 32'h1000, 32'hFFFFFFFF);
    issue(0, 0, 4'hF, 32'h0, 32'h0);
    issue(2, 1, 4'hF, 32'h10, 32'hCAFEF00D);
    @(negedge clk_i);
    drive(2, 0, 4'hF, 32'h10, 32'h0);
    @(posedge clk_i);
    #1;
    acc = cyc;
    push(2, 0, 4'hF, 32'h10, 32'h0, acc);
    push(2, 0, 4'hF, 32'h10, 32'h0, acc + 5);
    repeat (5) @(posedge clk_i);
    #1;
    scramble(2);
    wait_done();
    issue(1, 1, 4'hF, 32'h40, 32'h12345678);
    issue(1, 0, 4'hF, 32'h40, 32'h0);
    @(negedge clk_i);
    drive(1, 0, 4'hF, 32'h40, 32'h0);
    @(posedge clk_i);
    #1;
    scramble(1);
    @(negedge clk_i);
    arst_i = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("midreset_rvalid", {31'b0, rvalid[d]}, 0);
      chk("midreset_rdata", rdata[d], 0);
      chk("midreset_err", {31'b0, err[d]}, 0);
    end
    @(negedge clk_i);
    arst_i = 1'b0;
    issue(1, 0, 4'hF, 32'h40, 32'h0, 0);
    for (int i = 0; i < 30; i++) begin
      int d = int'($urandom_range(0, 2));
      bit w = 1'($urandom);
      logic [31:0] a = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 255))
                                                    : 32'($urandom_range(0, 63));
      issue(d, w, 4'($urandom), a, $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_data_mem.md
RV_DATA_MEM -- requirements
Module: rv_data_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit memory words (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 1, meaning cycles from request acceptance to response (legal range 1..8).
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port arst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_req_i  input  1  request valid from the LSU.
REQ-006 SHALL have port data_we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port data_be_i  input  XLEN/8  byte enables; bit k qualifies bits 8k+7:8k.
REQ-008 SHALL have port data_addr_i  input  XLEN  byte address; bits 1:0 are ignored.
REQ-009 SHALL have port data_wdata_i  input  XLEN  store data, already lane-aligned by the LSU.
REQ-010 SHALL have port data_rvalid_o  output  1  one-cycle response strobe for loads and stores.
REQ-011 SHALL have port data_rdata_o  output  XLEN  load data; qualified by data_rvalid_o.
REQ-012 SHALL have port data_err_o  output  1  out-of-range access flag; qualified by data_rvalid_o.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and RESP.
REQ-014 SHALL accept a request only in IDLE; data_req_i high at a rising edge in IDLE counts as acceptance.
REQ-015 SHALL latch we, be, addr and wdata at acceptance; later input changes SHALL NOT affect the transaction.
REQ-016 SHALL transition on acceptance to RESP when LATENCY=1, otherwise to BUSY with the latency counter loaded to LATENCY-2.
REQ-017 SHALL decrement the counter in BUSY and move to RESP when it reads 0.
REQ-018 SHALL assert data_rvalid_o for exactly one cycle, in RESP; RESP SHALL always return to IDLE.
REQ-019 SHALL produce data_rvalid_o in cycle N+LATENCY for a request accepted in cycle N.
REQ-020 SHALL allow at most one outstanding transaction; peak throughput is one per LATENCY+1 cycles.
REQ-021 SHALL ignore data_req_i in BUSY and RESP; a request still high when the FSM returns to IDLE is accepted then.
REQ-022 SHALL treat an address as in range when data_addr_i < 4*DEPTH_WORDS; the word index is data_addr_i[log2(DEPTH_WORDS)+1:2].
REQ-023 SHALL commit an in-range store at the acceptance edge, updating only the bytes whose data_be_i bit is set.
REQ-024 SHALL leave memory unchanged for a store with be = 0, but still send the response.
REQ-025 SHALL sample the read word at the acceptance edge, so a load never observes a store accepted later.
REQ-026 SHALL drive data_rdata_o in RESP as follows: the full read word for an in-range load; 0 for stores and for out-of-range accesses.
REQ-027 SHALL, for an out-of-range access: not write the array; drive data_err_o = 1 in RESP; drive data_err_o = 0 otherwise.
REQ-028 SHALL hold data_rdata_o and data_err_o at 0 whenever data_rvalid_o is 0.
REQ-029 SHALL complete a transaction once accepted, even if data_req_i falls early (LSU kill); the store stays committed and the response is still issued.
REQ-030 SHALL NOT apply a byte-enable or alignment check beyond REQ-007/REQ-008; lane selection belongs to the LSU.

Reset
REQ-031 SHALL force the following immediately on arst_i high, independent of clk_i: FSM = IDLE, counter = 0, data_rvalid_o = 0, data_rdata_o = 0, data_err_o = 0.
REQ-032 SHALL drop a pending transaction when reset hits mid-operation: no response is issued, and a store already committed at acceptance remains in memory.
REQ-033 SHALL NOT reset the memory array; its contents are undefined after power-up and preserved across arst_i.
REQ-034 SHALL accept a new request at the first rising edge after arst_i falls.

Verification
REQ-035 SHALL cover: LATENCY=1, store word 0xDEADBEEF to 0x10 with be=1111, then load 0x10 -> rvalid one cycle after each acceptance; load returns 0xDEADBEEF with err=0.
REQ-036 SHALL cover: memory preloaded with 0x11223344 at 0x20, store 0x0000AA00 with be=0010 -> a later load returns 0x1122AA44.
REQ-037 SHALL cover: LATENCY=4, load held high -> rvalid exactly 4 cycles after acceptance, next acceptance 5 cycles after the first, with no response while BUSY.
REQ-038 SHALL cover: DEPTH_WORDS=1024, load 0x00001000 -> rvalid with err=1 and rdata=0; store to 0x00001000 -> array unchanged and err=1.
REQ-039 SHALL cover: LATENCY=3, arst_i pulsed one cycle after a load is accepted -> rvalid never asserts and all outputs read 0 during reset.
REQ-040 SHALL cover: req dropped one cycle after acceptance of a store with LATENCY=3 -> rvalid still appears at N+3 and the store is visible to a later load.
